// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin owner of the async FIFO write port.
// Define FIFO_WARB_BURST_EN to hold a grant for up to MAX_BURST beats.
module fifo_write_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                        w_clk,
  input  logic                        wrst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                        w_full,
  output logic [N_REQ-1:0]            gnt,
  output logic                        w_en,
  output logic [DATA_WIDTH-1:0]       w_data,
  output logic                        busy
);

  localparam int OW = $clog2(N_REQ);

  typedef enum logic {
    ARB,
    GRANT
  } state_t;

  state_t              state;
  logic [OW-1:0]       owner;
  logic [OW-1:0]       pick;
  logic                pick_vld;
  logic                own_req;
  logic                accept;
  logic                last;
  logic [DATA_WIDTH-1:0] slice [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef FIFO_WARB_BURST_EN
  logic [3:0] beat_cnt;
  assign last = (beat_cnt + 4'd1) == 4'(MAX_BURST);
`else
  assign last = 1'b1;
`endif

  assign own_req = req[owner];
  assign accept  = (state == GRANT) && own_req && !w_full;
  assign w_en    = accept;
  assign busy    = (state == GRANT);

  // first requester above the current owner, wrapping at N_REQ
  always_comb begin
    int            idx;
    logic [OW-1:0] cand;
    idx      = 0;
    cand     = '0;
    pick     = owner;
    pick_vld = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx  = (int'(owner) + k) % N_REQ;
      cand = OW'(idx);
      if (!pick_vld && req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // owner's strobe and data, gated by full and state
  always_comb begin
    gnt    = '0;
    w_data = '0;
    if (accept) gnt[owner] = 1'b1;
    if (state == GRANT) w_data = slice[owner];
  end

  // arbitration state, owner and burst length
  always_ff @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= ARB;
      owner    <= OW'(N_REQ - 1);
`ifdef FIFO_WARB_BURST_EN
      beat_cnt <= '0;
`endif
    end else begin
      unique case (state)
        ARB: begin
          if (pick_vld) begin
            owner    <= pick;
            state    <= GRANT;
`ifdef FIFO_WARB_BURST_EN
            beat_cnt <= '0;
`endif
          end
        end
        GRANT: begin
          if (!own_req || (accept && last)) begin
            state <= ARB;
          end
`ifdef FIFO_WARB_BURST_EN
          else if (accept) begin
            beat_cnt <= beat_cnt + 4'd1;
          end
`endif
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: scoreboard bench for fifo_write_arbiter.
// Burst expectations follow FIFO_WARB_BURST_EN.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
`ifdef FIFO_WARB_BURST_EN
  localparam int BL = MB;
`else
  localparam int BL = 1;
`endif

  typedef struct packed {
    logic [N-1:0]  g;
    logic [DW-1:0] d;
  } wr_t;

  logic          w_clk = 1'b0;
  logic          wrst_n;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic          w_full;
  logic [N-1:0]  gnt;
  logic          w_en;
  logic [DW-1:0] w_data;
  logic          busy;

  logic [3:0]    beats [N];
  logic [N-1:0]  gnt_s;
  int            exp_beat [N];
  wr_t           sbq [$];
  int            checks = 0;
  int            failures = 0;

  fifo_write_arbiter #(
    .N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)
  ) dut (
    .w_clk(w_clk), .wrst_n(wrst_n), .req(req),
    .req_data(req_data), .w_full(w_full), .gnt(gnt),
    .w_en(w_en), .w_data(w_data), .busy(busy)
  );

  always #5 w_clk = ~w_clk;

  function automatic logic [DW-1:0] dat(int i, int b);
    logic [3:0] ii;
    logic [3:0] bb;
    ii = 4'(i);
    bb = 4'(b);
    return 8'hA5 ^ {ii, bb};
  endfunction

  // requester data word tracks how many beats it has delivered
  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++)
      req_data[i*DW +: DW] = dat(i, int'(beats[i]));
  end

  always @(negedge w_clk) gnt_s <= gnt;

  always @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < N; i++) beats[i] <= 4'd0;
    end else begin
      for (int i = 0; i < N; i++)
        if (gnt_s[i]) beats[i] <= beats[i] + 4'd1;
    end
  end

  task automatic push_exp(input int i, input int n);
    wr_t e;
    for (int k = 0; k < n; k++) begin
      e.g = '0;
      e.g[i] = 1'b1;
      e.d = dat(i, exp_beat[i]);
      exp_beat[i]++;
      sbq.push_back(e);
    end
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    req    = '0;
    w_full = 1'b0;
    sbq.delete();
    for (int i = 0; i < N; i++) exp_beat[i] = 0;
    repeat (2) @(posedge w_clk);
    @(negedge w_clk);
    wrst_n = 1'b1;
    @(posedge w_clk);
    #1;
  endtask

  task automatic test_reset();
    wrst_n = 1'b0;
    req    = 4'b1111;
    w_full = 1'b0;
    @(negedge w_clk);
    checks++;
    if (gnt !== 4'b0) begin
      failures++;
      $display("FAIL rst_gnt got %b required 0000", gnt);
    end
    checks++;
    if (w_en !== 1'b0) begin
      failures++;
      $display("FAIL rst_wen got %b required 0", w_en);
    end
    checks++;
    if (w_data !== 8'h00) begin
      failures++;
      $display("FAIL rst_wdata got %h required 00", w_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy got %b required 0", busy);
    end
  endtask

  task automatic test_single();
    wr_t e;
    do_reset();
    req = 4'b0001;
    push_exp(0, 1);
    @(negedge w_clk);
    checks++;
    if ({busy, w_en} !== 2'b00) begin
      failures++;
      $display("FAIL single_arb got busy=%b w_en=%b required 0 0", busy, w_en);
    end
    @(posedge w_clk); #1;
    @(negedge w_clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL single_busy got %b required 1", busy);
    end
    if (w_en) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL single_extra got gnt=%b required no write", gnt);
      end else begin
        e = sbq.pop_front();
        if ({gnt, w_data} !== {e.g, e.d}) begin
          failures++;
          $display("FAIL single_write got gnt=%b data=%h required gnt=%b data=%h",
                   gnt, w_data, e.g, e.d);
        end
      end
    end
    @(posedge w_clk); #1;
    req = '0;
    repeat (2) begin
      @(negedge w_clk);
      checks++;
      if (w_en !== 1'b0) begin
        failures++;
        $display("FAIL single_idle got w_en=%b required 0", w_en);
      end
      @(posedge w_clk); #1;
    end
    @(negedge w_clk);
    checks++;
    if (busy !== 1'b0 || sbq.size() != 0) begin
      failures++;
      $display("FAIL single_done got busy=%b left=%0d required 0 0", busy, sbq.size());
    end
  endtask

  task automatic test_round_robin();
    wr_t e;
    int  nw;
    int  total;
    nw    = 0;
    total = 4 * (BL + 1);
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) push_exp(i, BL);
    for (int c = 0; c < total; c++) begin
      @(negedge w_clk);
      checks++;
      if (busy !== ((c % (BL + 1)) != 0)) begin
        failures++;
        $display("FAIL rr_busy cycle %0d got %b required %b", c, busy, (c % (BL + 1)) != 0);
      end
      if (w_en) begin
        nw++;
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL rr_extra got gnt=%b required no write", gnt);
        end else begin
          e = sbq.pop_front();
          if ({gnt, w_data} !== {e.g, e.d}) begin
            failures++;
            $display("FAIL rr_write got gnt=%b data=%h required gnt=%b data=%h",
                     gnt, w_data, e.g, e.d);
          end
        end
      end
      @(posedge w_clk); #1;
    end
    req = '0;
    checks++;
    if (nw != 4 * BL || sbq.size() != 0) begin
      failures++;
      $display("FAIL rr_count got %0d writes left=%0d required %0d left=0", nw, sbq.size(), 4 * BL);
    end
  endtask

  task automatic test_full_stall();
    wr_t e;
    int  pre;
    int  total;
    logic full;
    pre   = (BL >= 4) ? 2 : 0;
    total = 1 + pre + 3 + (BL - pre) + 1;
    do_reset();
    push_exp(2, BL);
    for (int c = 0; c < total; c++) begin
      full   = (c >= 1 + pre) && (c < 4 + pre);
      w_full = full;
      req    = (c == total - 1) ? 4'b0000 : 4'b0100;
      @(negedge w_clk);
      checks++;
      if (busy !== ((c >= 1) && (c < total - 1))) begin
        failures++;
        $display("FAIL stall_busy cycle %0d got %b", c, busy);
      end
      if (full) begin
        checks++;
        if (gnt !== 4'b0 || w_en !== 1'b0) begin
          failures++;
          $display("FAIL stall_gate cycle %0d got gnt=%b w_en=%b required 0000 0", c, gnt, w_en);
        end
      end
      if (w_en) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL stall_extra got gnt=%b required no write", gnt);
        end else begin
          e = sbq.pop_front();
          if ({gnt, w_data} !== {e.g, e.d}) begin
            failures++;
            $display("FAIL stall_write got gnt=%b data=%h required gnt=%b data=%h",
                     gnt, w_data, e.g, e.d);
          end
        end
      end
      @(posedge w_clk); #1;
    end
    w_full = 1'b0;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL stall_left got %0d required 0", sbq.size());
    end
  endtask

  task automatic test_drop();
    wr_t e;
    int  nw;
    int  w2c;
    int  exp_c2;
    nw     = 0;
    w2c    = -1;
    exp_c2 = (BL > 1) ? 4 : 3;
    do_reset();
    push_exp(0, 1);
    push_exp(2, 1);
    for (int c = 0; c < 8; c++) begin
      if (nw >= 2)     req = 4'b0000;
      else if (c >= 2) req = 4'b0100;
      else             req = 4'b0101;
      @(negedge w_clk);
      if (c == exp_c2 - 1) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL drop_arb cycle %0d got busy=%b required 0", c, busy);
        end
      end
      if (w_en) begin
        nw++;
        if (nw == 2) w2c = c;
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL drop_extra got gnt=%b required no write", gnt);
        end else begin
          e = sbq.pop_front();
          if ({gnt, w_data} !== {e.g, e.d}) begin
            failures++;
            $display("FAIL drop_write got gnt=%b data=%h required gnt=%b data=%h",
                     gnt, w_data, e.g, e.d);
          end
        end
      end
      @(posedge w_clk); #1;
    end
    req = '0;
    checks++;
    if (w2c != exp_c2 || sbq.size() != 0) begin
      failures++;
      $display("FAIL drop_latency got cycle %0d left=%0d required cycle %0d left=0",
               w2c, sbq.size(), exp_c2);
    end
  endtask

  task automatic test_async_reset();
    wr_t e;
    do_reset();
    req = 4'b1111;
    @(negedge w_clk);
    @(posedge w_clk); #1;
    @(negedge w_clk);
    checks++;
    if (gnt !== 4'b0001 || w_en !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre got gnt=%b w_en=%b required 0001 1", gnt, w_en);
    end
    #2;
    wrst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, w_en, w_data, busy} !== 14'b0) begin
      failures++;
      $display("FAIL arst_out got gnt=%b w_en=%b data=%h busy=%b required all 0",
               gnt, w_en, w_data, busy);
    end
    repeat (2) @(posedge w_clk);
    @(negedge w_clk);
    wrst_n = 1'b1;
    sbq.delete();
    for (int i = 0; i < N; i++) exp_beat[i] = 0;
    push_exp(0, 1);
    @(posedge w_clk); #1;
    @(negedge w_clk);
    checks++;
    if (busy !== 1'b1 || w_en !== 1'b1) begin
      failures++;
      $display("FAIL arst_regrant got busy=%b w_en=%b required 1 1", busy, w_en);
    end
    if (w_en) begin
      checks++;
      e = sbq.pop_front();
      if ({gnt, w_data} !== {e.g, e.d}) begin
        failures++;
        $display("FAIL arst_write got gnt=%b data=%h required gnt=%b data=%h",
                 gnt, w_data, e.g, e.d);
      end
    end
    @(posedge w_clk); #1;
    req = '0;
    repeat (2) @(posedge w_clk);
    #1;
  endtask

  task automatic test_alternate();
    wr_t e;
    int  total;
    total = 3 * (BL + 1);
    do_reset();
    req = 4'b0011;
    push_exp(0, BL);
    push_exp(1, BL);
    push_exp(0, BL);
    for (int c = 0; c < total; c++) begin
      @(negedge w_clk);
      checks++;
      if (busy !== ((c % (BL + 1)) != 0)) begin
        failures++;
        $display("FAIL alt_busy cycle %0d got %b", c, busy);
      end
      if (w_en) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL alt_extra got gnt=%b required no write", gnt);
        end else begin
          e = sbq.pop_front();
          if ({gnt, w_data} !== {e.g, e.d}) begin
            failures++;
            $display("FAIL alt_write got gnt=%b data=%h required gnt=%b data=%h",
                     gnt, w_data, e.g, e.d);
          end
        end
      end
      @(posedge w_clk); #1;
    end
    req = '0;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL alt_left got %0d required 0", sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_drop();
    test_async_reset();
    test_alternate();
    repeat (2) @(posedge w_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the write port of the asynchronous FIFO write-clock domain between several requesters on `w_clk`. It selects one owner, forwards that owner's data, and drives `w_en` into the write-side pointer logic. It honours `w_full` so that no beat is lost and no requester is starved. It sits directly in front of the FIFO write port, entirely inside the write clock domain.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `DATA_WIDTH`, 8: FIFO word width.
- `MAX_BURST`, 4: maximum beats per grant when burst mode is compiled in (1..15).

- `w_clk`  in  1  write-domain clock; all state on the rising edge.
- `wrst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  N_REQ  per-requester write request; held high while the requester has data.
- `req_data`  in  N_REQ*DATA_WIDTH  flat data bus; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `w_full`  in  1  registered full flag from the FIFO write side.
- `gnt`  out  N_REQ  one-hot beat-accept strobe; requester i advances its data on a cycle with gnt[i]=1.
- `w_en`  out  1  FIFO write enable.
- `w_data`  out  DATA_WIDTH  FIFO write data, which is the owner's slice.
- `busy`  out  1  high while in the GRANT state.

## Operation
- Registered state:
  - State machine: ARB, GRANT.
  - `owner`: clog2(N_REQ) bits.
  - `beat_cnt`: 4 bits.
- **ARB**:
  - If `req` is non-zero, pick the first set bit scanning from owner+1 upward, wrapping modulo N_REQ.
  - Register that index as `owner`, clear `beat_cnt`, and go to GRANT.
  - If `req` is zero, stay in ARB with `owner` unchanged.
- **GRANT**:
  - gnt[owner] = req[owner] & !w_full. All other gnt bits are 0.
  - `w_en` = |gnt.
  - `w_data` = slice of `owner` whenever in GRANT; 0 in ARB.
  - An accepted beat is one where gnt[owner]=1. Each accepted beat increments `beat_cnt`.
- **Exit from GRANT to ARB** (next cycle) on any of:
  - req[owner]=0.
  - Accepted beat with beat_cnt+1 == burst limit.
- **Burst limit**: MAX_BURST with the configuration macro defined; 1 without it.
- **w_full=1 in GRANT**: no grant, no `w_en`. Owner and `beat_cnt` are held; the state stays in GRANT while req[owner] stays high.
- **Requester contract**: must not drop `req` in the same cycle it receives `gnt` unless that was its last beat. Dropping `req` without a grant forfeits ownership, and no data is written.
- **Wrap-around**: the round-robin scan wraps from N_REQ-1 to 0. The last owner has the lowest priority in the next ARB.
- **Reset (async, any time, including mid-burst)**:
  - state=ARB, owner=N_REQ-1 (so requester 0 has first priority), beat_cnt=0.
  - `gnt`, `w_en`, `w_data` and `busy` are all 0 immediately.

## Timing
- The `gnt`, `w_en` and `w_data` outputs are combinational from registered state plus `req`/`w_full`. No registered outputs beyond `busy` (= state==GRANT).
- Request-to-first-grant latency: 1 cycle (ARB cycle), then the grant is in the next cycle if `w_full`=0.
- Sustained throughput:
  - Burst mode: MAX_BURST beats per MAX_BURST+1 cycles.
  - Non-burst: 1 beat per 2 cycles.
- `w_full` asserts one cycle after the write that filled the FIFO. The downstream write logic already blocks on w_full, and the arbiter gates gnt with the same w_full, so the two never disagree.
- A simultaneous accepted last beat and req drop exits to ARB exactly once.

## Configuration
- `FIFO_WARB_BURST_EN` defined: grants last up to MAX_BURST accepted beats.
- Not defined: every grant is a single beat; `beat_cnt` is not instantiated, and MAX_BURST is ignored.

## Test plan
- **Reset, then single request**: req=0001, data 0xA5 → ARB for 1 cycle. Then gnt=0001, w_en=1, w_data=0xA5. Busy follows GRANT.
- **All four requesting continuously, burst on, MAX_BURST=4, w_full=0** → owners 0,1,2,3,0 in turn. Each owner gets 4 beats followed by 1 ARB cycle: 16 writes in 20 cycles.
- **w_full held high for 3 cycles mid-burst (owner 2 after 2 beats)** → gnt=0 and w_en=0 for those 3 cycles. Owner stays 2, then the remaining 2 beats complete.
- **Owner drops req after 1 beat of 4** → next cycle is ARB, and the next set requester above the owner wins.
- **wrst_n pulsed low mid-burst** → gnt, w_en and w_data go to 0 asynchronously. After release, req=1111 grants requester 0 first.
- **Macro undefined, req=0011 continuous** → gnt alternates 01, 10 with ARB cycles between, one beat each.
